// File: rtl/sum_accum_pkg.sv
// -----------------------------------------------------------------------------
// sum_accum_pkg
// Shared definitions for the frame accumulator: default widths, the FSM state
// encoding, and the frame-length decoding (a frame_len of 0 means 16 samples).
// Optional feature macro used by the top: SUM_ACCUM_PEAK_EN (adds out_peak).
// -----------------------------------------------------------------------------
package sum_accum_pkg;

    // Default datapath widths; the accumulator must cover 16 * (2^SUM_W - 1).
    localparam int unsigned SUM_W_DEF = 9;
    localparam int unsigned ACC_W_DEF = SUM_W_DEF + 4;

    // Frame length input width and sample counter width (counts 0..16).
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = LEN_W + 1;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ACCUM = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    // Frame length used when frame_len reads 0, and the reset value of len_q.
    localparam logic [CNT_W-1:0] LEN_ZERO_MEANS = CNT_W'(16);

    // Decode the 4-bit frame_len field into a sample count of 1..16.
    function automatic logic [CNT_W-1:0] decode_frame_len(input logic [LEN_W-1:0] fl);
        logic [CNT_W-1:0] len;
        len = CNT_W'(fl);
        if (fl == '0) begin
            len = LEN_ZERO_MEANS;
        end
        return len;
    endfunction

endpackage : sum_accum_pkg

// File: rtl/sum_accum_add.sv
// -----------------------------------------------------------------------------
// acc_add
// Unsigned accumulator adder: running total plus one zero-extended sample.
// The result is combinational and is registered by the caller.
//
// Parameters
//   SUM_W    : sample width
//   ACC_W    : accumulator width (sized by the caller so the sum never wraps)
// Ports
//   acc_i    : current accumulator value
//   sum_i    : incoming sample, zero-extended to ACC_W
//   sum_c_o  : acc_i + sample (combinational)
// -----------------------------------------------------------------------------
module acc_add #(
    parameter int unsigned SUM_W = 9,
    parameter int unsigned ACC_W = 13
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [SUM_W-1:0] sum_i,
    output logic [ACC_W-1:0] sum_c_o
);

    // Zero-extend the sample before adding; the accumulator width absorbs carries.
    assign sum_c_o = acc_i + ACC_W'(sum_i);

endmodule : acc_add

// File: rtl/sum_accum.sv
// -----------------------------------------------------------------------------
// sum_accum
// Frame accumulator behind the CLA final-sum stage. Sums a frame of 1..16
// unsigned samples with valid/ready handshakes on both sides and presents the
// frame total and sample count until the consumer takes them.
//
// FSM: IDLE -> ACCUM -> HOLD -> IDLE (IDLE -> HOLD directly for 1-sample frames).
//
// Parameters
//   SUM_W      : sample width (default 9)
//   ACC_W      : accumulator width (default 13 = SUM_W + 4)
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : in_sum valid this cycle
//   in_ready   : block accepts in_sum this cycle (1 in IDLE/ACCUM, 0 in HOLD)
//   in_sum     : unsigned sample
//   frame_len  : samples per frame, 0 means 16; sampled on a frame's first accept
//   out_valid  : frame result valid (exactly while in HOLD)
//   out_ready  : consumer accepts the result
//   out_acc    : frame total
//   out_count  : samples in the frame (1..16)
//   out_peak   : largest sample of the frame (only with SUM_ACCUM_PEAK_EN)
//
// Build option: define SUM_ACCUM_PEAK_EN to add the out_peak port and logic.
// -----------------------------------------------------------------------------
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic [LEN_W-1:0] frame_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count
`ifdef SUM_ACCUM_PEAK_EN
    ,
    output logic [SUM_W-1:0] out_peak
`endif
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [CNT_W-1:0] len_q,       len_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SUM_ACCUM_PEAK_EN
    logic [SUM_W-1:0] peak_q,      peak_d;
`endif

    logic             in_fire;
    logic             out_fire;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] first_len;

    // Transfers happen only on a full handshake.
    assign in_fire   = in_valid  && in_ready_q;
    assign out_fire  = out_valid_q && out_ready;
    assign count_inc = count_q + CNT_W'(1);
    assign first_len = decode_frame_len(frame_len);

    // -------------------------------------------------------------------------
    // Accumulator adder
    // -------------------------------------------------------------------------
    acc_add #(
        .SUM_W (SUM_W),
        .ACC_W (ACC_W)
    ) u_acc_add (
        .acc_i   (acc_q),
        .sum_i   (in_sum),
        .sum_c_o (acc_sum)
    );

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
`ifdef SUM_ACCUM_PEAK_EN
        peak_d  = peak_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // First sample of a frame: the only point where frame_len is sampled.
                if (in_fire) begin
                    len_d   = first_len;
                    acc_d   = ACC_W'(in_sum);
                    count_d = CNT_W'(1);
`ifdef SUM_ACCUM_PEAK_EN
                    peak_d  = in_sum;
`endif
                    state_d = (first_len == CNT_W'(1)) ? ST_HOLD : ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (in_fire) begin
                    acc_d   = acc_sum;
                    count_d = count_inc;
`ifdef SUM_ACCUM_PEAK_EN
                    if (in_sum > peak_q) begin
                        peak_d = in_sum;
                    end
`endif
                    if (count_inc == len_q) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                // Result is consumed; in_ready is already low so nothing enters this cycle.
                if (out_fire) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    count_d = '0;
`ifdef SUM_ACCUM_PEAK_EN
                    peak_d  = '0;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                count_d = '0;
`ifdef SUM_ACCUM_PEAK_EN
                peak_d  = '0;
`endif
            end
        endcase

        // Handshake flags are registered copies of the next state's decode.
        in_ready_d  = (state_d != ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            len_q       <= LEN_ZERO_MEANS;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SUM_ACCUM_PEAK_EN
    // Running frame maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign out_peak = peak_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs, all straight from registers
    // -------------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = count_q;

endmodule : sum_accum

// File: tb/tb_sum_accum.sv
// -----------------------------------------------------------------------------
// tb_sum_accum
// Self-checking bench for sum_accum. A reference model keeps the samples of the
// current frame in a queue; the expected total, count and peak are computed
// from that queue with plain arithmetic. Define SUM_ACCUM_PEAK_EN to also
// check out_peak.
// -----------------------------------------------------------------------------
module tb_sum_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_sum;
    logic [3:0]  frame_len;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_acc;
    logic [4:0]  out_count;
`ifdef SUM_ACCUM_PEAK_EN
    logic [8:0]  out_peak;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: samples of the frame in progress and its length.
    logic [8:0] frm[$];
    int         mlen = 16;

    sum_accum #(
        .SUM_W (9),
        .ACC_W (13)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .frame_len (frame_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count)
`ifdef SUM_ACCUM_PEAK_EN
        ,
        .out_peak  (out_peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_sum();
        int s = 0;
        foreach (frm[i]) s += int'(frm[i]);
        return s;
    endfunction

    function automatic int model_peak();
        int p = 0;
        foreach (frm[i]) if (int'(frm[i]) > p) p = int'(frm[i]);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample after `gap` idle cycles and wait for it to be accepted.
    task automatic accept(input logic [8:0] v, input logic [3:0] fl, input int gap);
        int w;
        for (int g = 0; g < gap; g++) begin
            in_valid  = 1'b0;
            in_sum    = 9'($urandom);
            frame_len = 4'($urandom);
            tick();
        end
        in_valid  = 1'b1;
        in_sum    = v;
        frame_len = fl;
        w = 0;
        while (in_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        if (frm.size() == 0) mlen = (fl == 4'd0) ? 16 : int'(fl);
        frm.push_back(v);
        tick();
        in_valid = 1'b0;
    endtask

    // Check the presented result, hold it under backpressure, then consume it.
    task automatic finish_frame(input int hold);
        chk("out_valid_after_last", 32'(out_valid), 32'd1);
        chk("out_acc", 32'(out_acc), 32'(model_sum()));
        chk("out_count", 32'(out_count), 32'(frm.size()));
        chk("in_ready_in_hold", 32'(in_ready), 32'd0);
`ifdef SUM_ACCUM_PEAK_EN
        chk("out_peak", 32'(out_peak), 32'(model_peak()));
`endif
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_sum   = 9'($urandom);
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_acc", 32'(out_acc), 32'(model_sum()));
            chk("bp_out_count", 32'(out_count), 32'(frm.size()));
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_acc_clear", 32'(out_acc), 32'd0);
        chk("post_hs_count_clear", 32'(out_count), 32'd0);
`ifdef SUM_ACCUM_PEAK_EN
        chk("post_hs_peak_clear", 32'(out_peak), 32'd0);
`endif
        frm.delete();
    endtask

    // Whole frame from a sample list, random gaps up to maxgap.
    task automatic send_frame(input logic [8:0] vals[$], input logic [3:0] fl,
                              input int maxgap, input int hold);
        foreach (vals[i]) begin
            accept(vals[i], (i == 0) ? fl : 4'($urandom),
                   (i == 0) ? 0 : int'($urandom_range(0, maxgap)));
        end
        finish_frame(hold);
    endtask

    // Pulse reset and check the cleared, ready state while it is held.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_acc"}, 32'(out_acc), 32'd0);
        chk({tag, "_out_count"}, 32'(out_count), 32'd0);
        tick();
        rst = 1'b0;
        frm.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_no_result"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [8:0] q[$];
        int         n;
        logic [3:0] fl;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        frame_len = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_acc", 32'(out_acc), 32'd0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef SUM_ACCUM_PEAK_EN
        chk("reset_out_peak", 32'(out_peak), 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Basic frame, back-to-back, consumer ready.
        out_ready = 1'b1;
        q = '{9'd1, 9'd255, 9'd256};
        send_frame(q, 4'd3, 0, 0);

        // Max load: 16 samples of 511 must not wrap.
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(9'd511);
        send_frame(q, 4'd0, 0, 0);

        // Backpressure for 5 cycles with in_valid held high.
        q = '{9'd100, 9'd200};
        send_frame(q, 4'd2, 0, 5);

        // Gaps and a mid-frame frame_len change.
        accept(9'd10, 4'd2, 0);
        accept(9'd20, 4'd7, 3);
        finish_frame(0);

        // Single-sample frame goes straight to HOLD.
        accept(9'd77, 4'd1, 0);
        finish_frame(1);

        // Reset mid-frame, then a clean frame of 5s.
        accept(9'd300, 4'd4, 0);
        accept(9'd400, 4'd9, 0);
        pulse_reset("rst_mid");
        q = '{9'd5, 9'd5, 9'd5, 9'd5};
        send_frame(q, 4'd4, 0, 0);

        // Reset while a result is pending.
        accept(9'd50, 4'd2, 0);
        accept(9'd60, 4'd2, 0);
        chk("pending_out_valid", 32'(out_valid), 32'd1);
        pulse_reset("rst_hold");

        // Peak frame.
        q = '{9'd3, 9'd400, 9'd7, 9'd399};
        send_frame(q, 4'd4, 1, 2);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            fl = 4'($urandom_range(0, 15));
            n  = (fl == 4'd0) ? 16 : int'(fl);
            q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0:       q.push_back(9'd511);
                    1:       q.push_back(9'd0);
                    default: q.push_back(9'($urandom));
                endcase
            end
            send_frame(q, fl, 2, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sum_accum
